// File: rtl/clk_div_prog.sv
// Programmable integer clock divider. Divisor changes and stops land on period boundaries.
// Ports: clk_in, rst(n, async), en, div_val, div_load, resync -> clk_out, tick, busy.
module clk_div_prog #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  input  logic             resync,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_W   = (CNT_W+1)'(1);

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [CNT_W-1:0] r_n_act, w_n_act_nx;
  logic [CNT_W-1:0] r_pend, w_pend_nx;
  logic             r_pend_v, w_pend_v_nx;
  logic             r_clk, w_clk_nx;
  logic             r_tick, w_tick_nx;

  logic [CNT_W-1:0] w_ld_val;
  logic [CNT_W:0]   w_hi;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_wrap;
  logic             w_bnd;

  // Clamp 0/1 to 2 so a period always has a high and a low phase.
  assign w_ld_val  = (div_val < DIV_MIN) ? DIV_MIN : div_val;

  // One extra bit so HI and cnt+1 stay exact at the top divisor.
  assign w_hi      = ({1'b0, r_n_act} + ONE_W) >> 1;
  assign w_cnt_inc = {1'b0, r_cnt} + ONE_W;

  assign w_wrap    = (r_cnt == (r_n_act - ONE));
  assign w_bnd     = w_wrap | resync;

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_n_act_nx  = r_n_act;
    w_clk_nx    = r_clk;
    w_tick_nx   = 1'b0;
    // A load in the same cycle as a boundary wins over the stored value.
    w_pend_nx   = div_load ? w_ld_val : r_pend;
    w_pend_v_nx = div_load | r_pend_v;

    unique case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nx = RUN;
          w_cnt_nx   = '0;
          w_clk_nx   = 1'b1;
          w_tick_nx  = 1'b1;
          if (w_pend_v_nx) begin
            w_n_act_nx  = w_pend_nx;
            w_pend_v_nx = 1'b0;
          end
        end
      end
      RUN: begin
        unique case (1'b1)
          (w_bnd && en): begin
            w_cnt_nx  = '0;
            w_clk_nx  = 1'b1;
            w_tick_nx = 1'b1;
            if (w_pend_v_nx) begin
              w_n_act_nx  = w_pend_nx;
              w_pend_v_nx = 1'b0;
            end
          end
          (w_bnd && !en): begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
            w_clk_nx   = 1'b0;
          end
          default: begin
            w_cnt_nx = w_cnt_inc[CNT_W-1:0];
            w_clk_nx = (w_cnt_inc < w_hi);
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_n_act  <= DIV_RST;
      r_pend   <= DIV_RST;
      r_pend_v <= 1'b0;
      r_clk    <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_n_act  <= w_n_act_nx;
      r_pend   <= w_pend_nx;
      r_pend_v <= w_pend_v_nx;
      r_clk    <= w_clk_nx;
      r_tick   <= w_tick_nx;
    end
  end

  assign clk_out = r_clk;
  assign tick    = r_tick;
  assign busy    = (r_state == RUN);

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with an expected-output queue.
// Each step pushes expected {clk_out,tick,busy} per cycle; outputs are popped 1ns after posedge.
module tb_clk_div_prog;

  localparam int CNT_W = 16;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             resync;
  logic             clk_out;
  logic             tick;
  logic             busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  string       phase = "init";
  logic [2:0]  q[$];

  clk_div_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .resync   (resync),
    .clk_out  (clk_out),
    .tick     (tick),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic cmp(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s/%s cyc=%0d observed=%b expected=%b",
             phase, tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input logic c, input logic t, input logic b);
    q.push_back({c, t, b});
  endtask

  // First k cycles of a running period of divisor n.
  task automatic push_part(input int n, input int k);
    int hi;
    hi = (n + 1) / 2;
    for (int i = 0; i < k; i++)
      push(i < hi, i == 0, 1'b1);
  endtask

  task automatic push_period(input int n);
    push_part(n, n);
  endtask

  task automatic chk_now();
    logic [2:0] e;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s/queue cyc=%0d observed=empty expected=entry", phase, cyc);
    end else begin
      e = q.pop_front();
      cmp("clk_out", clk_out, e[2]);
      cmp("tick",    tick,    e[1]);
      cmp("busy",    busy,    e[0]);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
      cyc++;
      chk_now();
    end
  endtask

  initial begin
    rst      = 1'b0;
    en       = 1'b0;
    div_val  = '0;
    div_load = 1'b0;
    resync   = 1'b0;

    phase = "reset";
    #1;
    push(0, 0, 0); chk_now();
    push(0, 0, 0); step(1);
    rst = 1'b1;
    push(0, 0, 0); step(1);

    phase = "t1_default4";
    en = 1'b1;
    repeat (3) push_period(4);
    step(12);
    en = 1'b0;
    push(0, 0, 0); step(1);

    phase = "t2_n5";
    div_val = 16'd5; div_load = 1'b1;
    push(0, 0, 0); step(1);
    div_load = 1'b0; en = 1'b1;
    repeat (2) push_period(5);
    step(10);
    en = 1'b0;
    push(0, 0, 0); step(1);

    phase = "t3_4to6";
    div_val = 16'd4; div_load = 1'b1;
    push(0, 0, 0); step(1);
    div_load = 1'b0; en = 1'b1;
    push_period(4);
    step(1);
    div_val = 16'd6; div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    step(2);
    repeat (2) push_period(6);
    step(12);
    en = 1'b0;
    push(0, 0, 0); step(1);

    phase = "t4_stop_n8";
    div_val = 16'd8; div_load = 1'b1;
    push(0, 0, 0); step(1);
    div_load = 1'b0; en = 1'b1;
    push_period(8);
    step(3);
    en = 1'b0;
    step(5);
    push(0, 0, 0); step(1);
    push(0, 0, 0); step(1);

    phase = "t5_clamp0";
    div_val = 16'd0; div_load = 1'b1;
    push(0, 0, 0); step(1);
    div_load = 1'b0; en = 1'b1;
    repeat (3) push_period(2);
    step(6);

    phase = "t5_clamp1_at_bnd";
    div_val = 16'd1; div_load = 1'b1;
    repeat (2) push_period(2);
    step(1);
    div_load = 1'b0;
    step(3);

    phase = "t5_load3_at_bnd";
    div_val = 16'd3; div_load = 1'b1;
    repeat (2) push_period(3);
    step(1);
    div_load = 1'b0;
    step(5);
    en = 1'b0;
    push(0, 0, 0); step(1);

    phase = "t5_max";
    div_val = 16'hFFFF; div_load = 1'b1;
    push(0, 0, 0); step(1);
    div_load = 1'b0; en = 1'b1;
    push_period(65535);
    push(1, 1, 1);
    step(65536);

    phase = "resync_en0";
    resync = 1'b1; en = 1'b0;
    push(0, 0, 0); step(1);
    resync = 1'b0;

    phase = "t6_resync";
    div_val = 16'd8; div_load = 1'b1;
    push(0, 0, 0); step(1);
    div_load = 1'b0; en = 1'b1;
    push_part(8, 4);
    step(4);
    resync = 1'b1;
    push_period(8);
    step(1);
    resync = 1'b0;
    step(6);
    en = 1'b0;
    step(1);
    push(0, 0, 0); step(1);

    phase = "resync_idle";
    resync = 1'b1;
    push(0, 0, 0); step(1);
    resync = 1'b0;

    phase = "t6_reset_mid";
    en = 1'b1;
    push_part(8, 3);
    step(3);
    div_val = 16'd6; div_load = 1'b1;
    push(1, 0, 1); step(1);
    div_load = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    push(0, 0, 0); chk_now();
    #1;
    rst = 1'b1;

    phase = "after_reset";
    push_period(4);
    step(4);
    en = 1'b0;
    push(0, 0, 0); step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
